// File: rtl/dram_cmd_sched_pkg.sv
// Shared definitions for the DRAM command scheduler: arbiter states,
// cache-line offset and command-type bit values.
package dram_cmd_sched_pkg;

  typedef enum logic {
    ARB_RD = 1'b0,
    ARB_WR = 1'b1
  } arb_state_e;

  localparam int LINE_OFS = 4;

  localparam logic CMD_RD = 1'b1;
  localparam logic CMD_WR = 1'b0;

endpackage

// File: rtl/dram_cmd_sched_if.sv
// Upstream address-queue heads and downstream command-queue head of the scheduler.
interface dram_cmd_sched_if #(
  parameter int ADDRW = 32,
  parameter int QAW   = 2
);

  logic             wcmd_wen;
  logic [ADDRW-1:0] waddr;
  logic             wcmd_ack;
  logic             rcmd_wen;
  logic [ADDRW-1:0] raddr;
  logic             rcmd_ack;
  logic             rnext;
  logic             rqempty;
  logic [ADDRW-1:0] qraddr;
  logic             rd_bwt;
  logic [QAW:0]     qcount;

  modport master (
    output wcmd_wen, waddr, rcmd_wen, raddr, rnext,
    input  wcmd_ack, rcmd_ack, rqempty, qraddr, rd_bwt, qcount
  );

  modport slave (
    input  wcmd_wen, waddr, rcmd_wen, raddr, rnext,
    output wcmd_ack, rcmd_ack, rqempty, qraddr, rd_bwt, qcount
  );

endinterface

// File: rtl/dram_cmd_sched_sfifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
module dram_cmd_sched_sfifo #(
  parameter int SFIFODW = 33,
  parameter int SFIFOAW = 2,
  parameter int SFIFODP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [SFIFODW-1:0] din,
  input  logic               pop,
  output logic [SFIFODW-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic [SFIFOAW:0]   count
);

  logic [SFIFODW-1:0] mem [SFIFODP];
  logic [SFIFOAW-1:0] wptr;
  logic [SFIFOAW-1:0] rptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (SFIFOAW+1)'(SFIFODP));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + SFIFOAW'(1);
      if (do_pop)  rptr <= rptr + SFIFOAW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (SFIFOAW+1)'(1);
        2'b01:   count <= count - (SFIFOAW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/dram_cmd_sched.sv
// Read-first command arbiter feeding an in-order command queue towards the MIG,
// with read-streak / write-burst limits and a same-line read-after-write guard.
module dram_cmd_sched
  import dram_cmd_sched_pkg::*;
#(
  parameter int ADDRW  = 32,
  parameter int QAW    = 2,
  parameter int QDEPTH = 4,
  parameter int MAXRD  = 4,
  parameter int MAXWR  = 4
) (
  input logic              mclk,
  input logic              mrst_n,
  dram_cmd_sched_if.slave  bus
);

  localparam int RSW = $clog2(MAXRD + 1);
  localparam int WBW = $clog2(MAXWR + 1);
  localparam logic [RSW-1:0] RD_LAST = RSW'(MAXRD - 1);
  localparam logic [RSW-1:0] RD_SAT  = RSW'(MAXRD);
  localparam logic [WBW-1:0] WR_LAST = WBW'(MAXWR - 1);
  localparam logic [WBW-1:0] WR_SAT  = WBW'(MAXWR);

  arb_state_e     state, state_nxt;
  logic [RSW-1:0] rd_streak, rd_streak_nxt;
  logic [WBW-1:0] wr_burst, wr_burst_nxt;
  logic           grant_rd;
  logic           grant_wr;
  logic           hazard;
  logic           q_full;
  logic           q_empty;
  logic [ADDRW:0] q_din;
  logic [ADDRW:0] q_head;

  function automatic logic [RSW-1:0] sat_inc_rd(input logic [RSW-1:0] v);
    return (v == RD_SAT) ? v : v + RSW'(1);
  endfunction

  function automatic logic [WBW-1:0] sat_inc_wr(input logic [WBW-1:0] v);
    return (v == WR_SAT) ? v : v + WBW'(1);
  endfunction

  assign hazard = bus.wcmd_wen & bus.rcmd_wen &
                  (bus.raddr[ADDRW-1:LINE_OFS] == bus.waddr[ADDRW-1:LINE_OFS]);

  // Full check uses the registered occupancy; a pop this cycle does not open a slot.
  always_comb begin
    state_nxt     = state;
    rd_streak_nxt = rd_streak;
    wr_burst_nxt  = wr_burst;
    grant_rd      = 1'b0;
    grant_wr      = 1'b0;
    if (mrst_n && !q_full) begin
      unique case (state)
        ARB_RD: begin
          if (hazard) begin
            grant_wr      = 1'b1;
            rd_streak_nxt = '0;
            wr_burst_nxt  = '0;
            state_nxt     = ARB_WR;
          end else if (bus.rcmd_wen) begin
            grant_rd      = 1'b1;
            rd_streak_nxt = bus.wcmd_wen ? sat_inc_rd(rd_streak) : '0;
            if (rd_streak == RD_LAST) begin
              wr_burst_nxt = '0;
              state_nxt    = ARB_WR;
            end
          end else if (bus.wcmd_wen) begin
            grant_wr      = 1'b1;
            rd_streak_nxt = '0;
          end else begin
            rd_streak_nxt = '0;
          end
        end
        ARB_WR: begin
          if (bus.wcmd_wen) begin
            grant_wr      = 1'b1;
            rd_streak_nxt = '0;
            wr_burst_nxt  = sat_inc_wr(wr_burst);
            if (wr_burst == WR_LAST) state_nxt = ARB_RD;
          end else begin
            grant_rd      = bus.rcmd_wen;
            rd_streak_nxt = '0;
            state_nxt     = ARB_RD;
          end
        end
        default: state_nxt = ARB_RD;
      endcase
    end
  end

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      state     <= ARB_RD;
      rd_streak <= '0;
      wr_burst  <= '0;
    end else begin
      state     <= state_nxt;
      rd_streak <= rd_streak_nxt;
      wr_burst  <= wr_burst_nxt;
    end
  end

  assign bus.wcmd_ack = grant_wr;
  assign bus.rcmd_ack = grant_rd;
  assign q_din        = grant_rd ? {CMD_RD, bus.raddr} : {CMD_WR, bus.waddr};

  dram_cmd_sched_sfifo #(
    .SFIFODW (ADDRW + 1),
    .SFIFOAW (QAW),
    .SFIFODP (QDEPTH)
  ) u_cmd_q (
    .clk   (mclk),
    .rst_n (mrst_n),
    .push  (grant_rd | grant_wr),
    .din   (q_din),
    .pop   (bus.rnext),
    .dout  (q_head),
    .empty (q_empty),
    .full  (q_full),
    .count (bus.qcount)
  );

  assign bus.rqempty = q_empty;
  assign bus.rd_bwt  = q_head[ADDRW];
  assign bus.qraddr  = q_head[ADDRW-1:0];

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Directed bench for dram_cmd_sched: upstream queue models drive the heads and a
// scoreboard checks every command the MIG side consumes against the expected order.
module tb_dram_cmd_sched;

  localparam int ADDRW = 32;
  localparam int QAW   = 2;

  logic mclk = 1'b0;
  logic mrst_n = 1'b0;
  always #5 mclk = ~mclk;

  dram_cmd_sched_if #(.ADDRW(ADDRW), .QAW(QAW)) bus ();

  dram_cmd_sched #(
    .ADDRW(ADDRW), .QAW(QAW), .QDEPTH(4), .MAXRD(4), .MAXWR(4)
  ) dut (
    .mclk   (mclk),
    .mrst_n (mrst_n),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int wack_cnt = 0;
  int rack_cnt = 0;
  logic last_w, last_r;
  logic [ADDRW:0]   exp_q[$];
  logic [ADDRW:0]   mon_e;
  logic [ADDRW-1:0] wq[$];
  logic [ADDRW-1:0] rq[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void exp_rd(input logic [ADDRW-1:0] a);
    exp_q.push_back({1'b1, a});
  endfunction

  function automatic void exp_wr(input logic [ADDRW-1:0] a);
    exp_q.push_back({1'b0, a});
  endfunction

  task automatic drive_src();
    bus.wcmd_wen = (wq.size() > 0);
    bus.waddr    = (wq.size() > 0) ? wq[0] : '0;
    bus.rcmd_wen = (rq.size() > 0);
    bus.raddr    = (rq.size() > 0) ? rq[0] : '0;
  endtask

  // One clock: sample acks away from the edge, then pop the upstream models.
  task automatic step();
    @(negedge mclk);
    last_w = bus.wcmd_ack;
    last_r = bus.rcmd_ack;
    check("single_grant", 64'(last_w & last_r), 64'd0);
    @(posedge mclk);
    #1;
    if (last_w) begin void'(wq.pop_front()); wack_cnt++; end
    if (last_r) begin void'(rq.pop_front()); rack_cnt++; end
    drive_src();
  endtask

  task automatic drain();
    int k;
    k = 0;
    bus.rnext = 1'b1;
    while ((!bus.rqempty || wq.size() > 0 || rq.size() > 0) && k < 60) begin
      step();
      k++;
    end
    check("drain_in_budget", 64'(k < 60), 64'd1);
    check("sb_all_consumed", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rqempty"}, 64'(bus.rqempty), 64'd1);
    check({tag, "_qcount"},  64'(bus.qcount),  64'd0);
    check({tag, "_wack"},    64'(bus.wcmd_ack), 64'd0);
    check({tag, "_rack"},    64'(bus.rcmd_ack), 64'd0);
    check({tag, "_qraddr"},  64'(bus.qraddr),  64'd0);
    check({tag, "_rd_bwt"},  64'(bus.rd_bwt),  64'd0);
  endtask

  // Scoreboard monitor: every head consumed by the MIG side must match the next expected command.
  always @(negedge mclk) begin
    if (mrst_n && bus.rnext && !bus.rqempty) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got 0x%0h expected none", {bus.rd_bwt, bus.qraddr});
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_head", 64'({bus.rd_bwt, bus.qraddr}), 64'(mon_e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rnext = 1'b0;
    drive_src();
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    check_reset_outputs("reset");
    @(posedge mclk);
    #1;
    mrst_n = 1'b1;

    // Reads only
    rq = '{32'h100, 32'h110, 32'h120};
    exp_rd(32'h100); exp_rd(32'h110); exp_rd(32'h120);
    rack_cnt = 0; wack_cnt = 0;
    bus.rnext = 1'b1;
    drive_src();
    repeat (6) step();
    check("t1_rack_cnt", 64'(rack_cnt), 64'd3);
    check("t1_wack_cnt", 64'(wack_cnt), 64'd0);
    drain();

    // Both always valid: RRRR WWWW RRRR WWWW
    rack_cnt = 0; wack_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      rq.push_back(32'h3000 + 32'(i * 16));
      wq.push_back(32'h5000 + 32'(i * 16));
    end
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) exp_rd(32'h3000 + 32'((g * 4 + i) * 16));
      for (int i = 0; i < 4; i++) exp_wr(32'h5000 + 32'((g * 4 + i) * 16));
    end
    drive_src();
    drain();
    check("t2_rack_cnt", 64'(rack_cnt), 64'd8);
    check("t2_wack_cnt", 64'(wack_cnt), 64'd8);

    // Same-line hazard: write goes first
    wq = '{32'h2008};
    rq = '{32'h2000};
    exp_wr(32'h2008); exp_rd(32'h2000);
    drive_src();
    step();
    check("t3_first_is_write", 64'({last_w, last_r}), 64'b10);
    step();
    check("t3_then_read", 64'({last_w, last_r}), 64'b01);
    drain();

    // Full queue stalls grants
    bus.rnext = 1'b0;
    rack_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      rq.push_back(32'h400 + 32'(i * 16));
      exp_rd(32'h400 + 32'(i * 16));
    end
    drive_src();
    repeat (5) step();
    check("t4_rack_cnt", 64'(rack_cnt), 64'd4);
    check("t4_qcount_full", 64'(bus.qcount), 64'd4);
    check("t4_no_ack_full", 64'({last_w, last_r}), 64'd0);
    bus.rnext = 1'b1;
    step();
    check("t4_no_grant_same_cycle", 64'({last_w, last_r}), 64'd0);
    check("t4_qcount_after_pop", 64'(bus.qcount), 64'd3);
    bus.rnext = 1'b0;
    step();
    check("t4_grant_after_pop", 64'({last_w, last_r}), 64'b01);
    check("t4_qcount_refill", 64'(bus.qcount), 64'd4);
    drain();

    // Reset mid-stream discards queued commands
    bus.rnext = 1'b0;
    rq = '{32'h600, 32'h610, 32'h620, 32'h630};
    drive_src();
    repeat (3) step();
    check("t5_qcount_before", 64'(bus.qcount), 64'd3);
    mrst_n = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    step();
    check("t5_upstream_kept", 64'(rq.size()), 64'd1);
    mrst_n = 1'b1;
    for (int i = 4; i < 8; i++) rq.push_back(32'h600 + 32'(i * 16));
    wq = '{32'h7000};
    exp_rd(32'h630); exp_rd(32'h640); exp_rd(32'h650); exp_rd(32'h660);
    exp_wr(32'h7000); exp_rd(32'h670);
    drive_src();
    drain();

    // Push and pop together at qcount=2
    bus.rnext = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rq.push_back(32'h800 + 32'(i * 16));
      exp_rd(32'h800 + 32'(i * 16));
    end
    drive_src();
    repeat (2) step();
    check("t6_qcount_start", 64'(bus.qcount), 64'd2);
    bus.rnext = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t6_qcount_steady", 64'(bus.qcount), 64'd2);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
